// File: rtl/riscv_pkg.sv
// Shared decode/execute definitions: datapath widths, the x0 index, the
// all-zero control bundle, and the per-edge action of the ID/EX register.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int REGW  = 5;
  localparam int CTRLW = 16;

  localparam logic [REGW-1:0]  X0       = '0;
  localparam logic [CTRLW-1:0] CTRL_NOP = '0;

  // What the execute slot does on the next rising edge.
  typedef enum logic [1:0] {
    SLOT_CAPTURE = 2'd0,  // load the decode-stage instruction
    SLOT_BUBBLE  = 2'd1,  // load an all-zero NOP
    SLOT_HOLD    = 2'd2   // keep contents, refresh operands from writeback
  } slot_op_e;

  // Flush beats hold; an empty decode slot captures as a bubble, but only
  // when the execute stage is actually advancing.
  function automatic slot_op_e slot_op(input logic valid_d,
                                       input logic hold_e,
                                       input logic flush_e);
    slot_op_e op;
    if (flush_e)       op = SLOT_BUBBLE;
    else if (hold_e)   op = SLOT_HOLD;
    else if (!valid_d) op = SLOT_BUBBLE;
    else               op = SLOT_CAPTURE;
    return op;
  endfunction

endpackage

// File: rtl/id_ex_reg_wb_bypass.sv
// Writeback bypass for one operand: substitutes the value being written this
// edge when it targets the operand's source register. x0 never bypasses.
module wb_bypass
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int REGW = riscv_pkg::REGW
) (
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] rdata,
  input  logic            we_w,
  input  logic [REGW-1:0] rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] operand
);

  logic hit;

  // Hit when the writeback lands on the register this operand reads.
  assign hit     = we_w && (rd_w != REGW'(X0)) && (rd_w == rs);
  assign operand = hit ? result_w : rdata;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Captures decode operands with a same-edge
// writeback bypass, keeps held operands current during stalls, inserts
// bubbles on flush or empty decode, and flags load-use hazards.
module id_ex_reg
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int REGW  = riscv_pkg::REGW,
  parameter int CTRLW = riscv_pkg::CTRLW
) (
  input  logic             clk,
  input  logic             reset_n,
  // decode stage
  input  logic             valid_d,
  input  logic [REGW-1:0]  rs1_d,
  input  logic [REGW-1:0]  rs2_d,
  input  logic [REGW-1:0]  rd_d,
  input  logic [XLEN-1:0]  rd1_d,
  input  logic [XLEN-1:0]  rd2_d,
  input  logic [XLEN-1:0]  imm_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [CTRLW-1:0] ctrl_d,
  input  logic             is_load_d,
  // writeback port (same nets that drive the register file)
  input  logic             we_w,
  input  logic [REGW-1:0]  rd_w,
  input  logic [XLEN-1:0]  result_w,
  // hazard control
  input  logic             hold_e,
  input  logic             flush_e,
  // execute stage
  output logic             valid_e,
  output logic [REGW-1:0]  rs1_e,
  output logic [REGW-1:0]  rs2_e,
  output logic [REGW-1:0]  rd_e,
  output logic [XLEN-1:0]  rd1_e,
  output logic [XLEN-1:0]  rd2_e,
  output logic [XLEN-1:0]  imm_e,
  output logic [XLEN-1:0]  pc_e,
  output logic [CTRLW-1:0] ctrl_e,
  output logic             is_load_e,
  output logic             load_use
);

  logic             valid_e_q,   valid_e_d;
  logic [REGW-1:0]  rs1_e_q,     rs1_e_d;
  logic [REGW-1:0]  rs2_e_q,     rs2_e_d;
  logic [REGW-1:0]  rd_e_q,      rd_e_d;
  logic [XLEN-1:0]  rd1_e_q,     rd1_e_d;
  logic [XLEN-1:0]  rd2_e_q,     rd2_e_d;
  logic [XLEN-1:0]  imm_e_q,     imm_e_d;
  logic [XLEN-1:0]  pc_e_q,      pc_e_d;
  logic [CTRLW-1:0] ctrl_e_q,    ctrl_e_d;
  logic             is_load_e_q, is_load_e_d;

  logic [XLEN-1:0]  cap_rd1, cap_rd2;
  logic [XLEN-1:0]  hold_rd1, hold_rd2;
  slot_op_e         op;

  // Capture path: decode operands corrected for a write on the same edge.
  wb_bypass #(.XLEN(XLEN), .REGW(REGW)) u_cap_rs1 (
    .rs(rs1_d), .rdata(rd1_d), .we_w(we_w), .rd_w(rd_w),
    .result_w(result_w), .operand(cap_rd1)
  );

  wb_bypass #(.XLEN(XLEN), .REGW(REGW)) u_cap_rs2 (
    .rs(rs2_d), .rdata(rd2_d), .we_w(we_w), .rd_w(rd_w),
    .result_w(result_w), .operand(cap_rd2)
  );

  // Hold path: held operands refreshed by writebacks arriving during a stall.
  wb_bypass #(.XLEN(XLEN), .REGW(REGW)) u_hold_rs1 (
    .rs(rs1_e_q), .rdata(rd1_e_q), .we_w(we_w), .rd_w(rd_w),
    .result_w(result_w), .operand(hold_rd1)
  );

  wb_bypass #(.XLEN(XLEN), .REGW(REGW)) u_hold_rs2 (
    .rs(rs2_e_q), .rdata(rd2_e_q), .we_w(we_w), .rd_w(rd_w),
    .result_w(result_w), .operand(hold_rd2)
  );

  assign op = slot_op(valid_d, hold_e, flush_e);

  // Next-state selection for the execute slot: capture, bubble or hold.
  always_comb begin
    // NOTE: every next-state signal gets a default before the case so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    valid_e_d   = valid_e_q;
    rs1_e_d     = rs1_e_q;
    rs2_e_d     = rs2_e_q;
    rd_e_d      = rd_e_q;
    rd1_e_d     = rd1_e_q;
    rd2_e_d     = rd2_e_q;
    imm_e_d     = imm_e_q;
    pc_e_d      = pc_e_q;
    ctrl_e_d    = ctrl_e_q;
    is_load_e_d = is_load_e_q;

    unique case (op)
      SLOT_CAPTURE: begin
        valid_e_d   = 1'b1;
        rs1_e_d     = rs1_d;
        rs2_e_d     = rs2_d;
        rd_e_d      = rd_d;
        rd1_e_d     = cap_rd1;
        rd2_e_d     = cap_rd2;
        imm_e_d     = imm_d;
        pc_e_d      = pc_d;
        ctrl_e_d    = ctrl_d;
        is_load_e_d = is_load_d;
      end
      SLOT_HOLD: begin
        // A bubble has nothing to refresh; only a live slot tracks writebacks.
        if (valid_e_q) begin
          rd1_e_d = hold_rd1;
          rd2_e_d = hold_rd2;
        end
      end
      default: begin
        valid_e_d   = 1'b0;
        rs1_e_d     = REGW'(X0);
        rs2_e_d     = REGW'(X0);
        rd_e_d      = REGW'(X0);
        rd1_e_d     = '0;
        rd2_e_d     = '0;
        imm_e_d     = '0;
        pc_e_d      = '0;
        ctrl_e_d    = CTRLW'(CTRL_NOP);
        is_load_e_d = 1'b0;
      end
    endcase
  end

  // Execute-slot registers; asynchronous reset clears the slot to a NOP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_e_q   <= 1'b0;
      rs1_e_q     <= REGW'(X0);
      rs2_e_q     <= REGW'(X0);
      rd_e_q      <= REGW'(X0);
      rd1_e_q     <= '0;
      rd2_e_q     <= '0;
      imm_e_q     <= '0;
      pc_e_q      <= '0;
      ctrl_e_q    <= CTRLW'(CTRL_NOP);
      is_load_e_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge next-state values regardless of statement order.
      valid_e_q   <= valid_e_d;
      rs1_e_q     <= rs1_e_d;
      rs2_e_q     <= rs2_e_d;
      rd_e_q      <= rd_e_d;
      rd1_e_q     <= rd1_e_d;
      rd2_e_q     <= rd2_e_d;
      imm_e_q     <= imm_e_d;
      pc_e_q      <= pc_e_d;
      ctrl_e_q    <= ctrl_e_d;
      is_load_e_q <= is_load_e_d;
    end
  end

  // Load in execute whose destination is read by the decode instruction.
  assign load_use = valid_e_q && is_load_e_q && (rd_e_q != REGW'(X0)) &&
                    valid_d && ((rd_e_q == rs1_d) || (rd_e_q == rs2_d));

  assign valid_e   = valid_e_q;
  assign rs1_e     = rs1_e_q;
  assign rs2_e     = rs2_e_q;
  assign rd_e      = rd_e_q;
  assign rd1_e     = rd1_e_q;
  assign rd2_e     = rd2_e_q;
  assign imm_e     = imm_e_q;
  assign pc_e      = pc_e_q;
  assign ctrl_e    = ctrl_e_q;
  assign is_load_e = is_load_e_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a register-file
// level reference model.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [31:0] rd1_d, rd2_d, imm_d, pc_d;
  logic [15:0] ctrl_d;
  logic        is_load_d;
  logic        we_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        hold_e, flush_e;
  logic        valid_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e;
  logic [15:0] ctrl_e;
  logic        is_load_e;
  logic        load_use;

  int n_vec  = 0;
  int n_fail = 0;

  id_ex_reg dut (
    .clk(clk), .reset_n(reset_n),
    .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d),
    .ctrl_d(ctrl_d), .is_load_d(is_load_d),
    .we_w(we_w), .rd_w(rd_w), .result_w(result_w),
    .hold_e(hold_e), .flush_e(flush_e),
    .valid_e(valid_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e),
    .ctrl_e(ctrl_e), .is_load_e(is_load_e), .load_use(load_use)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2;
    logic [15:0] ctrl;
    logic        we;
    logic [4:0]  rdw;
    logic [31:0] res;
    logic        flush;
    logic        exp_valid;
    logic [31:0] exp_rd1, exp_rd2;
    logic [4:0]  exp_rd;
    logic [15:0] exp_ctrl;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm, pc;
    logic [15:0] ctrl;
    logic        is_load;
  } slot_t;

  vec_t        vecs[9];
  logic [31:0] rf[32];
  slot_t       exp_slot;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    valid_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0; rd1_d = 0; rd2_d = 0;
    imm_d = 0; pc_d = 0; ctrl_d = 0; is_load_d = 0;
    we_w = 0; rd_w = 0; result_w = 0; hold_e = 0; flush_e = 0;
  endtask

  function automatic vec_t mk(input string name, input logic valid,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] rd1, input logic [31:0] rd2, input logic [15:0] ctrl,
                              input logic we, input logic [4:0] rdw, input logic [31:0] res,
                              input logic flush, input logic ev, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [4:0] erd, input logic [15:0] ectrl);
    vec_t v;
    v.name = name; v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.rd1 = rd1; v.rd2 = rd2; v.ctrl = ctrl; v.we = we; v.rdw = rdw; v.res = res;
    v.flush = flush; v.exp_valid = ev; v.exp_rd1 = e1; v.exp_rd2 = e2;
    v.exp_rd = erd; v.exp_ctrl = ectrl;
    return v;
  endfunction

  task automatic check_slot(input string tag, input slot_t s);
    check({tag, ".valid_e"},   64'(valid_e),   64'(s.valid));
    check({tag, ".rs1_e"},     64'(rs1_e),     64'(s.rs1));
    check({tag, ".rs2_e"},     64'(rs2_e),     64'(s.rs2));
    check({tag, ".rd_e"},      64'(rd_e),      64'(s.rd));
    check({tag, ".rd1_e"},     64'(rd1_e),     64'(s.rd1));
    check({tag, ".rd2_e"},     64'(rd2_e),     64'(s.rd2));
    check({tag, ".imm_e"},     64'(imm_e),     64'(s.imm));
    check({tag, ".pc_e"},      64'(pc_e),      64'(s.pc));
    check({tag, ".ctrl_e"},    64'(ctrl_e),    64'(s.ctrl));
    check({tag, ".is_load_e"}, 64'(is_load_e), 64'(s.is_load));
  endtask

  initial begin
    slot_t zero_slot;
    zero_slot = '{valid: 0, rs1: 0, rs2: 0, rd: 0, rd1: 0, rd2: 0,
                  imm: 0, pc: 0, ctrl: 0, is_load: 0};

    set_idle();
    #11;
    check_slot("reset", zero_slot);
    check("reset.load_use", 64'(load_use), 64'd0);
    @(negedge clk);
    reset_n = 1;

    // ---------------- directed capture vectors ----------------
    //           name        v  rs1 rs2 rd  rd1        rd2        ctrl      we rdw res          fl  ev exp_rd1    exp_rd2    erd ectrl
    vecs[0] = mk("plain",    1, 1,  2,  3,  32'h101,   32'h202,   16'h00A5, 0, 0,  32'h0,       0, 1, 32'h101,   32'h202,   3,  16'h00A5);
    vecs[1] = mk("byp_rs1",  1, 5,  6,  7,  32'h11,    32'h66,    16'h0011, 1, 5,  32'hAA,      0, 1, 32'hAA,    32'h66,    7,  16'h0011);
    vecs[2] = mk("x0_guard", 1, 0,  4,  8,  32'h0,     32'h44,    16'h0022, 1, 0,  32'hFF,      0, 1, 32'h0,     32'h44,    8,  16'h0022);
    vecs[3] = mk("byp_both", 1, 9,  9,  10, 32'h9,     32'h9,     16'h0033, 1, 9,  32'hCAFE,    0, 1, 32'hCAFE,  32'hCAFE,  10, 16'h0033);
    vecs[4] = mk("we_off",   1, 9,  8,  11, 32'h90,    32'h91,    16'h0044, 0, 9,  32'hDEAD,    0, 1, 32'h90,    32'h91,    11, 16'h0044);
    vecs[5] = mk("byp_rs2",  1, 2,  31, 12, 32'h2,     32'h1F,    16'h0055, 1, 31, 32'h5555,    0, 1, 32'h2,     32'h5555,  12, 16'h0055);
    vecs[6] = mk("bubble",   0, 1,  1,  13, 32'h1,     32'h1,     16'hFFFF, 1, 1,  32'h77,      0, 0, 32'h0,     32'h0,     0,  16'h0000);
    vecs[7] = mk("flush",    1, 3,  4,  14, 32'h3,     32'h4,     16'h1234, 0, 0,  32'h0,       1, 0, 32'h0,     32'h0,     0,  16'h0000);
    vecs[8] = mk("rd_miss",  1, 13, 11, 15, 32'hD,     32'hB,     16'h0066, 1, 12, 32'h1212,    0, 1, 32'hD,     32'hB,     15, 16'h0066);

    for (int i = 0; i < 9; i++) begin
      set_idle();
      valid_d = vecs[i].valid; rs1_d = vecs[i].rs1; rs2_d = vecs[i].rs2; rd_d = vecs[i].rd;
      rd1_d = vecs[i].rd1; rd2_d = vecs[i].rd2; ctrl_d = vecs[i].ctrl;
      imm_d = 32'h100 + i; pc_d = 32'h4000 + 4 * i;
      we_w = vecs[i].we; rd_w = vecs[i].rdw; result_w = vecs[i].res; flush_e = vecs[i].flush;
      tick();
      check({vecs[i].name, ".valid_e"}, 64'(valid_e), 64'(vecs[i].exp_valid));
      check({vecs[i].name, ".rd1_e"},   64'(rd1_e),   64'(vecs[i].exp_rd1));
      check({vecs[i].name, ".rd2_e"},   64'(rd2_e),   64'(vecs[i].exp_rd2));
      check({vecs[i].name, ".rd_e"},    64'(rd_e),    64'(vecs[i].exp_rd));
      check({vecs[i].name, ".ctrl_e"},  64'(ctrl_e),  64'(vecs[i].exp_ctrl));
    end

    // ---------------- hold refresh over a 3-cycle stall ----------------
    set_idle();
    valid_d = 1; rs1_d = 2; rs2_d = 7; rd_d = 9; rd1_d = 32'h22; rd2_d = 32'h77;
    imm_d = 32'h5; pc_d = 32'h800; ctrl_d = 16'h0F0F;
    tick();
    set_idle();
    hold_e = 1; valid_d = 1; rs1_d = 4; rd1_d = 32'h9999;   // stalled decode
    tick();
    check("hold1.rd2_e", 64'(rd2_e), 64'h77);
    check("hold1.pc_e",  64'(pc_e),  64'h800);
    we_w = 1; rd_w = 7; result_w = 32'h1234;
    tick();
    check("hold2.rd2_e",  64'(rd2_e),  64'h1234);
    check("hold2.rd1_e",  64'(rd1_e),  64'h22);
    check("hold2.rd_e",   64'(rd_e),   64'd9);
    check("hold2.rs1_e",  64'(rs1_e),  64'd2);
    check("hold2.ctrl_e", 64'(ctrl_e), 64'h0F0F);
    we_w = 0;
    tick();
    check("hold3.rd2_e", 64'(rd2_e), 64'h1234);
    check("hold3.imm_e", 64'(imm_e), 64'h5);

    // ---------------- load-use then flush ----------------
    set_idle();
    valid_d = 1; rs1_d = 1; rs2_d = 2; rd_d = 3; is_load_d = 1; ctrl_d = 16'hBEEF;
    tick();
    set_idle();
    valid_d = 1; rs1_d = 1; rs2_d = 6;
    #1;
    check("lu.no_match", 64'(load_use), 64'd0);
    rs2_d = 3;
    #1;
    check("lu.rs2_match", 64'(load_use), 64'd1);
    valid_d = 0;
    #1;
    check("lu.d_invalid", 64'(load_use), 64'd0);
    valid_d = 1; hold_e = 1; flush_e = 1;
    tick();
    check("lu_flush.valid_e", 64'(valid_e), 64'd0);
    check("lu_flush.rd_e",    64'(rd_e),    64'd0);
    check("lu_flush.ctrl_e",  64'(ctrl_e),  64'd0);
    check("lu_flush.load_use", 64'(load_use), 64'd0);

    // load to x0 never raises load_use
    set_idle();
    valid_d = 1; rd_d = 0; is_load_d = 1;
    tick();
    valid_d = 1; rs1_d = 0; rs2_d = 0; is_load_d = 0;
    #1;
    check("lu.x0", 64'(load_use), 64'd0);

    // ---------------- flush over hold ----------------
    set_idle();
    valid_d = 1; rs1_d = 5; rd_d = 6; rd1_d = 32'h55; ctrl_d = 16'h0001;
    tick();
    set_idle();
    hold_e = 1; flush_e = 1;
    tick();
    check("fovh.valid_e", 64'(valid_e), 64'd0);
    check("fovh.rd1_e",   64'(rd1_e),   64'd0);
    check("fovh.rd_e",    64'(rd_e),    64'd0);

    // ---------------- asynchronous reset mid-stall ----------------
    set_idle();
    valid_d = 1; rs1_d = 4; rd_d = 4; is_load_d = 1; rd1_d = 32'h4444; pc_d = 32'h44; ctrl_d = 16'h4;
    tick();
    set_idle();
    hold_e = 1; valid_d = 1; rs2_d = 4;
    #1;
    check("rst.pre_load_use", 64'(load_use), 64'd1);
    #2;
    reset_n = 0;
    #1;
    check_slot("rst_mid", zero_slot);
    check("rst_mid.load_use", 64'(load_use), 64'd0);
    @(negedge clk);
    reset_n = 1;

    // ---------------- randomized traffic vs register-file model ----------------
    for (int r = 0; r < 32; r++) rf[r] = (r == 0) ? 32'h0 : $urandom;
    exp_slot = zero_slot;
    set_idle();
    tick();
    check_slot("rand_start", exp_slot);

    for (int c = 0; c < 250; c++) begin
      logic [31:0] rf_new[32];
      logic        exp_lu;
      valid_d   = ($urandom_range(0, 9) < 8);
      rs1_d     = 5'($urandom_range(0, 7));
      rs2_d     = 5'($urandom_range(0, 7));
      rd_d      = 5'($urandom_range(0, 7));
      rd1_d     = rf[rs1_d];
      rd2_d     = rf[rs2_d];
      imm_d     = $urandom;
      pc_d      = $urandom;
      ctrl_d    = 16'($urandom);
      is_load_d = ($urandom_range(0, 2) == 0);
      we_w      = ($urandom_range(0, 4) < 3);
      rd_w      = 5'($urandom_range(0, 7));
      result_w  = $urandom;
      hold_e    = ($urandom_range(0, 9) < 3);
      flush_e   = ($urandom_range(0, 9) == 0);
      #1;
      exp_lu = exp_slot.valid && exp_slot.is_load && (exp_slot.rd != 0) && valid_d &&
               ((exp_slot.rd == rs1_d) || (exp_slot.rd == rs2_d));
      check($sformatf("rand%0d.load_use", c), 64'(load_use), 64'(exp_lu));

      // Architectural register file after this edge's writeback.
      rf_new = rf;
      if (we_w && rd_w != 0) rf_new[rd_w] = result_w;

      // A live execute slot always presents the post-writeback register
      // contents of its sources; a dead slot is all zeros.
      if (flush_e || (!hold_e && !valid_d)) begin
        exp_slot = zero_slot;
      end else if (!hold_e) begin
        exp_slot = '{valid: 1, rs1: rs1_d, rs2: rs2_d, rd: rd_d, rd1: 0, rd2: 0,
                     imm: imm_d, pc: pc_d, ctrl: ctrl_d, is_load: is_load_d};
      end
      if (exp_slot.valid) begin
        exp_slot.rd1 = rf_new[exp_slot.rs1];
        exp_slot.rd2 = rf_new[exp_slot.rs2];
      end
      rf = rf_new;

      tick();
      check_slot($sformatf("rand%0d", c), exp_slot);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Decode-to-execute pipeline register sitting directly downstream of the register file. It captures both register read ports plus decode-stage operands, and repairs the same-cycle write/read race: the register file writes on the clock edge while its reads are combinational. It also keeps held operands coherent during execute-stage stalls and reports load-use hazards to the hazard unit. Execute-stage forwarding from MEM and WB remains in the existing forwarding mux; this block only guarantees that the values it presents are current as of the last writeback.

## Interface
Parameters:
- XLEN, 32, data/operand width
- REGW, 5, register index width
- CTRLW, 16, width of opaque decoded control bundle

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid_d  in  1  decode slot holds a real instruction
- rs1_d, rs2_d  in  REGW  source indices driven to register file read addresses
- rd_d  in  REGW  destination index
- rd1_d, rd2_d  in  XLEN  register file read data
- imm_d, pc_d  in  XLEN  immediate, instruction PC
- ctrl_d  in  CTRLW  decoded control bundle
- is_load_d  in  1  instruction is a load
- we_w  in  1  writeback enable (same net as register file write enable)
- rd_w  in  REGW  writeback destination
- result_w  in  XLEN  writeback data
- hold_e  in  1  keep execute register contents
- flush_e  in  1  insert bubble into execute
- valid_e, rs1_e, rs2_e, rd_e, rd1_e, rd2_e, imm_e, pc_e, ctrl_e, is_load_e  out  as inputs  registered execute-stage copies
- load_use  out  1  combinational: load in E blocks decode instruction

## Operation
- Bypass term: byp(rs) = we_w && rd_w != 0 && rd_w == rs.
- Capture (no hold, no flush): every field <= its _d input, except:
  - rd1_e <= byp(rs1_d) ? result_w : rd1_d
  - rd2_e <= byp(rs2_d) ? result_w : rd2_d
- rs = 0 never bypasses; the captured value is rd1_d/rd2_d, which the register file guarantees is 0.
- Hold (hold_e=1, flush_e=0): all fields keep their value, except:
  - rd1_e <= result_w if valid_e && byp(rs1_e)
  - rd2_e <= result_w if valid_e && byp(rs2_e)
  - This prevents stale operands after a multi-cycle stall.
- Flush (flush_e=1): valid_e, is_load_e, ctrl_e, rd_e, rs1_e, rs2_e <= 0; data fields <= 0.
  - Flush overrides hold.
  - A flushed slot is a NOP: rd_e=0 and all-zero ctrl means no side effects.
- valid_d=0 captures as a bubble with all fields zeroed, same as flush.
- load_use = valid_e && is_load_e && rd_e != 0 && valid_d && ((rd_e == rs1_d) || (rd_e == rs2_d)).
  - Purely combinational.
  - The hazard unit answers with a decode stall and flush_e in the same cycle.

## Timing
- Reset (async assert, sync-released by the top): every output register 0. load_use is therefore 0 out of reset.
- Latency: one cycle, D inputs to E outputs; bypass adds no cycle.
- Writeback and capture in the same edge: the captured value equals what the register file holds after that edge.
- rd_w matches both rs1_d and rs2_d: both operands bypass.
- hold_e and flush_e together: flush wins.
- Reset asserted mid-stall: contents drop to 0 immediately, independent of clk.

## Structure
- Shared package riscv_pkg holds XLEN, REGW, CTRLW, the constant X0 = 0, and the zero control bundle CTRL_NOP.
- One natural sub-module, wb_bypass:
  - Inputs: rs, rdata, we_w, rd_w, result_w
  - Output: the selected operand
  - Instanced twice for capture and twice for hold refresh; alternatively the same two instances are muxed on rs1_d/rs1_e.
- Everything else is flat register logic.

## Test plan
- Reset: assert reset_n=0 mid-cycle -> all outputs 0 immediately; load_use=0.
- Same-cycle bypass: rs1_d=5, rd1_d=0x11, we_w=1, rd_w=5, result_w=0xAA -> next cycle rd1_e=0xAA; rd2_e unaffected.
- x0 guard: rs1_d=0, rd1_d=0, we_w=1, rd_w=0, result_w=0xFF -> rd1_e=0.
- Hold refresh: E holds rs2_e=7 with hold_e=1 for 3 cycles; WB writes x7=0x1234 in cycle 2 -> rd2_e=0x1234 after that edge, other fields unchanged.
- Load-use: E holds a load with rd_e=3 (valid); D presents rs2_d=3 -> load_use=1 in that cycle. flush_e=1 on that edge -> valid_e=0, rd_e=0, ctrl_e=0.
- Flush-over-hold: hold_e=1 and flush_e=1 together -> bubble captured, valid_e=0.
